// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg
// Shared constants and types for the UART FIFO level controller.
//   DEPTH_DEF    : default FIFO depth in bytes
//   CNT_W        : width of the fill-level counters (holds 0..16)
//   TO_CHARS_DEF : default character times before RX timeout
//   dma_state_t  : DMA handshake state, DMA_ACTIVE drives *rdy_n low
package uart_fifo_pkg;

  localparam int CNT_W        = 5;
  localparam int DEPTH_DEF    = 16;
  localparam int TO_CHARS_DEF = 4;

  typedef enum logic {
    DMA_IDLE   = 1'b0,
    DMA_ACTIVE = 1'b1
  } dma_state_t;

endpackage

// File: rtl/uart_fifo_level.sv
// uart_fifo_level
// One FIFO fill counter with capacity limit and sticky overrun flag.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   push, pop : byte written / byte taken
//   clr       : zero the count and overrun (wins over push/pop)
//   cap       : current capacity (DEPTH or 1)
//   count     : fill level
//   overrun   : set by a push at capacity, cleared by clr
module uart_fifo_level
  import uart_fifo_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clr,
  input  logic [CNT_W-1:0] cap,
  output logic [CNT_W-1:0] count,
  output logic             overrun
);

  logic full;
  logic do_pop;

  assign full   = (count >= cap);
  assign do_pop = pop && (count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      overrun <= 1'b0;
    end else if (clr) begin
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      case ({push, do_pop})
        2'b10: begin
          if (full) overrun <= 1'b1;
          else      count   <= count + 1'b1;
        end
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl
// 16550-style FIFO level, clear, trigger, timeout and DMA-ready control.
// Optional feature macro: UART_FIFO_CTRL_TIMEOUT_EN builds the RX character
// timeout; without it rx_timeout is 0 and RX DMA reacts to rx_trig only.
// Ports:
//   m_clk, reset                     : clock, asynchronous active-high reset
//   fifoen, rxclr, txclr, dma_mode   : FCR bits (levels)
//   rxfiftl                          : RX trigger level in bytes
//   rx_push/rx_pop, tx_push/tx_pop   : FIFO traffic
//   char_tick                        : one pulse per character time
//   rx_count, tx_count               : fill levels
//   rx_fifo_clr, tx_fifo_clr         : one-cycle clear strobes to storage
//   rx_trig, rx_timeout, rx_overrun  : RX status
//   rxrdy_n, txrdy_n                 : DMA ready, active-low
//
// DMA state table (one instance each for RX and TX)
//   state      | meaning
//   DMA_IDLE   | *rdy_n high in DMA mode 1
//   DMA_ACTIVE | *rdy_n low in DMA mode 1
module uart_fifo_ctrl
  import uart_fifo_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int TO_CHARS = TO_CHARS_DEF
) (
  input  logic             m_clk,
  input  logic             reset,
  input  logic             fifoen,
  input  logic             rxclr,
  input  logic             txclr,
  input  logic             dma_mode,
  input  logic [3:0]       rxfiftl,
  input  logic             rx_push,
  input  logic             rx_pop,
  input  logic             tx_push,
  input  logic             tx_pop,
  input  logic             char_tick,
  output logic [CNT_W-1:0] rx_count,
  output logic [CNT_W-1:0] tx_count,
  output logic             rx_fifo_clr,
  output logic             tx_fifo_clr,
  output logic             rx_trig,
  output logic             rx_timeout,
  output logic             rx_overrun,
  output logic             rxrdy_n,
  output logic             txrdy_n
);

  logic             rxclr_q, txclr_q, fifoen_q, dma_mode_q;
  logic             fifoen_chg, rx_clr_now, tx_clr_now;
  logic [CNT_W-1:0] cap;
  logic             tx_ovr_unused;
  logic             rx_go;
  dma_state_t       rx_state, rx_state_d, tx_state, tx_state_d;

  assign cap        = fifoen ? CNT_W'(DEPTH) : CNT_W'(1);
  assign fifoen_chg = fifoen ^ fifoen_q;
  assign rx_clr_now = (rxclr & ~rxclr_q) | fifoen_chg;
  assign tx_clr_now = (txclr & ~txclr_q) | fifoen_chg;

  // Edge registers reset to 1 so FCR clear bits already high create no strobe.
  always_ff @(posedge m_clk or posedge reset) begin
    if (reset) begin
      rxclr_q     <= 1'b1;
      txclr_q     <= 1'b1;
      fifoen_q    <= 1'b0;
      rx_fifo_clr <= 1'b0;
      tx_fifo_clr <= 1'b0;
    end else begin
      rxclr_q     <= rxclr;
      txclr_q     <= txclr;
      fifoen_q    <= fifoen;
      rx_fifo_clr <= rx_clr_now;
      tx_fifo_clr <= tx_clr_now;
    end
  end

  uart_fifo_level u_rx_level (
    .clk     (m_clk),
    .rst     (reset),
    .push    (rx_push),
    .pop     (rx_pop),
    .clr     (rx_clr_now),
    .cap     (cap),
    .count   (rx_count),
    .overrun (rx_overrun)
  );

  uart_fifo_level u_tx_level (
    .clk     (m_clk),
    .rst     (reset),
    .push    (tx_push),
    .pop     (tx_pop),
    .clr     (tx_clr_now),
    .cap     (cap),
    .count   (tx_count),
    .overrun (tx_ovr_unused)
  );

  assign rx_trig = fifoen && (rxfiftl != 4'd0) && (rx_count >= CNT_W'(rxfiftl));

`ifdef UART_FIFO_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CHARS + 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge m_clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (rx_clr_now || rx_push || rx_pop || (rx_count == '0)) begin
      to_cnt <= '0;
    end else if (char_tick && (to_cnt != TO_W'(TO_CHARS))) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign rx_timeout = fifoen && (to_cnt == TO_W'(TO_CHARS));
  assign rx_go      = rx_trig || rx_timeout;
`else
  logic tick_unused;
  assign tick_unused = char_tick;
  assign rx_timeout  = 1'b0;
  assign rx_go       = rx_trig;
`endif

  always_ff @(posedge m_clk or posedge reset) begin
    if (reset) begin
      rx_state   <= DMA_IDLE;
      tx_state   <= DMA_ACTIVE;
      dma_mode_q <= 1'b0;
    end else begin
      rx_state   <= rx_state_d;
      tx_state   <= tx_state_d;
      dma_mode_q <= dma_mode;
    end
  end

  // In mode 0 (and on any mode change) the states shadow the mode-0 rules,
  // so entering mode 1 starts from a consistent handshake.
  always_comb begin
    rx_state_d = rx_state;
    tx_state_d = tx_state;
    if (!dma_mode || (dma_mode != dma_mode_q)) begin
      rx_state_d = (rx_count != '0) ? DMA_ACTIVE : DMA_IDLE;
      tx_state_d = (tx_count == '0) ? DMA_ACTIVE : DMA_IDLE;
    end else begin
      if (rx_state == DMA_IDLE) begin
        if (rx_go) rx_state_d = DMA_ACTIVE;
      end else if (rx_count == '0) begin
        rx_state_d = DMA_IDLE;
      end
      if (tx_state == DMA_IDLE) begin
        if (tx_count == '0) tx_state_d = DMA_ACTIVE;
      end else if (tx_count >= cap) begin
        tx_state_d = DMA_IDLE;
      end
    end
  end

  assign rxrdy_n = dma_mode ? (rx_state != DMA_ACTIVE) : (rx_count == '0);
  assign txrdy_n = dma_mode ? (tx_state != DMA_ACTIVE) : (tx_count != '0);

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
module tb_uart_fifo_ctrl;

  logic       m_clk = 1'b0;
  logic       reset;
  logic       fifoen, rxclr, txclr, dma_mode;
  logic [3:0] rxfiftl;
  logic       rx_push, rx_pop, tx_push, tx_pop, char_tick;
  logic [4:0] rx_count, tx_count;
  logic       rx_fifo_clr, tx_fifo_clr, rx_trig, rx_timeout, rx_overrun;
  logic       rxrdy_n, txrdy_n;

  int checks = 0;
  int errors = 0;

  always #5 m_clk = ~m_clk;

  uart_fifo_ctrl dut (
    .m_clk       (m_clk),
    .reset       (reset),
    .fifoen      (fifoen),
    .rxclr       (rxclr),
    .txclr       (txclr),
    .dma_mode    (dma_mode),
    .rxfiftl     (rxfiftl),
    .rx_push     (rx_push),
    .rx_pop      (rx_pop),
    .tx_push     (tx_push),
    .tx_pop      (tx_pop),
    .char_tick   (char_tick),
    .rx_count    (rx_count),
    .tx_count    (tx_count),
    .rx_fifo_clr (rx_fifo_clr),
    .tx_fifo_clr (tx_fifo_clr),
    .rx_trig     (rx_trig),
    .rx_timeout  (rx_timeout),
    .rx_overrun  (rx_overrun),
    .rxrdy_n     (rxrdy_n),
    .txrdy_n     (txrdy_n)
  );

  typedef struct {
    logic       rp, rpo, tp, tpo;
    logic       fen, rclr, tclr;
    logic [3:0] tl;
    int         erx, etx;
    logic       erc, etc_, etrig, eovr, erdy, etdy;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are read on the next falling edge.
  task automatic cyc(input logic rp, input logic rpo, input logic tp,
                     input logic tpo, input logic tk);
    rx_push = rp; rx_pop = rpo; tx_push = tp; tx_pop = tpo; char_tick = tk;
    @(negedge m_clk);
    rx_push = 0; rx_pop = 0; tx_push = 0; tx_pop = 0; char_tick = 0;
  endtask

  task automatic do_reset();
    fifoen = 0; rxclr = 0; txclr = 0; dma_mode = 0; rxfiftl = 0;
    rx_push = 0; rx_pop = 0; tx_push = 0; tx_pop = 0; char_tick = 0;
    reset = 1;
    @(negedge m_clk);
    @(negedge m_clk);
    reset = 0;
    @(negedge m_clk);
  endtask

  int pulses;

  initial begin
    vecs[0]  = '{0,0,1,0, 0,0,0,0, 0,1, 0,0,0,0,1,1};
    vecs[1]  = '{0,0,1,0, 0,0,0,0, 0,1, 0,0,0,0,1,1};
    vecs[2]  = '{1,0,0,0, 0,0,0,0, 1,1, 0,0,0,0,0,1};
    vecs[3]  = '{1,0,0,0, 0,0,0,0, 1,1, 0,0,0,1,0,1};
    vecs[4]  = '{0,0,0,0, 1,0,0,0, 0,0, 1,1,0,0,1,0};
    vecs[5]  = '{0,0,0,0, 1,0,0,0, 0,0, 0,0,0,0,1,0};
    vecs[6]  = '{1,0,1,0, 1,0,0,0, 1,1, 0,0,0,0,0,1};
    vecs[7]  = '{1,1,0,1, 1,0,0,0, 1,0, 0,0,0,0,0,0};
    vecs[8]  = '{0,1,0,1, 1,0,0,0, 0,0, 0,0,0,0,1,0};
    vecs[9]  = '{0,1,0,0, 1,0,0,0, 0,0, 0,0,0,0,1,0};
    vecs[10] = '{1,0,0,0, 1,0,0,2, 1,0, 0,0,0,0,0,0};
    vecs[11] = '{1,0,0,0, 1,0,0,2, 2,0, 0,0,1,0,0,0};
    vecs[12] = '{0,0,1,0, 1,0,1,2, 2,0, 0,1,1,0,0,0};
    vecs[13] = '{0,0,1,0, 1,0,1,2, 2,1, 0,0,1,0,0,1};
    vecs[14] = '{1,0,0,0, 1,1,0,2, 0,1, 1,0,0,0,1,1};
    vecs[15] = '{0,0,0,0, 1,1,0,2, 0,1, 0,0,0,0,1,1};

    do_reset();
    chk("reset rx_count", rx_count, 0);
    chk("reset tx_count", tx_count, 0);
    chk("reset clr strobes", {rx_fifo_clr, tx_fifo_clr}, 0);
    chk("reset overrun", rx_overrun, 0);
    chk("reset timeout", rx_timeout, 0);
    chk("reset rxrdy_n", rxrdy_n, 1);
    chk("reset txrdy_n", txrdy_n, 0);

    for (int i = 0; i < 16; i++) begin
      fifoen = vecs[i].fen; rxclr = vecs[i].rclr; txclr = vecs[i].tclr;
      rxfiftl = vecs[i].tl; dma_mode = 0;
      cyc(vecs[i].rp, vecs[i].rpo, vecs[i].tp, vecs[i].tpo, 0);
      chk($sformatf("v%0d rx_count", i), rx_count, vecs[i].erx);
      chk($sformatf("v%0d tx_count", i), tx_count, vecs[i].etx);
      chk($sformatf("v%0d rx_fifo_clr", i), rx_fifo_clr, vecs[i].erc);
      chk($sformatf("v%0d tx_fifo_clr", i), tx_fifo_clr, vecs[i].etc_);
      chk($sformatf("v%0d rx_trig", i), rx_trig, vecs[i].etrig);
      chk($sformatf("v%0d rx_overrun", i), rx_overrun, vecs[i].eovr);
      chk($sformatf("v%0d rxrdy_n", i), rxrdy_n, vecs[i].erdy);
      chk($sformatf("v%0d txrdy_n", i), txrdy_n, vecs[i].etdy);
    end

    // Fill RX to 16, then overflow.
    do_reset();
    fifoen = 1;
    cyc(0,0,0,0,0);
    for (int i = 0; i < 16; i++) cyc(1,0,0,0,0);
    chk("fill16 rx_count", rx_count, 16);
    chk("fill16 overrun", rx_overrun, 0);
    cyc(1,0,0,0,0);
    chk("push17 rx_count", rx_count, 16);
    chk("push17 overrun", rx_overrun, 1);

    // RX DMA mode 1 with trigger level 8.
    do_reset();
    fifoen = 1; rxfiftl = 8; dma_mode = 1;
    cyc(0,0,0,0,0);
    cyc(0,0,0,0,0);
    chk("dma rx idle rxrdy_n", rxrdy_n, 1);
    for (int i = 0; i < 7; i++) cyc(1,0,0,0,0);
    chk("dma rx 7 trig", rx_trig, 0);
    cyc(1,0,0,0,0);
    chk("dma rx 8 trig", rx_trig, 1);
    chk("dma rx 8 rxrdy_n same cycle", rxrdy_n, 1);
    cyc(0,0,0,0,0);
    chk("dma rx 8 rxrdy_n next", rxrdy_n, 0);
    for (int i = 0; i < 7; i++) cyc(0,1,0,0,0);
    chk("dma rx pop7 count", rx_count, 1);
    chk("dma rx pop7 rxrdy_n", rxrdy_n, 0);
    cyc(0,1,0,0,0);
    cyc(0,0,0,0,0);
    chk("dma rx empty rxrdy_n", rxrdy_n, 1);

    // Character timeout.
    do_reset();
    fifoen = 1;
    cyc(0,0,0,0,0);
    for (int i = 0; i < 3; i++) cyc(1,0,0,0,0);
    for (int i = 0; i < 3; i++) cyc(0,0,0,0,1);
    chk("timeout after 3 ticks", rx_timeout, 0);
    cyc(0,0,0,0,1);
`ifdef UART_FIFO_CTRL_TIMEOUT_EN
    chk("timeout after 4 ticks", rx_timeout, 1);
    cyc(0,0,0,0,1);
    chk("timeout saturated", rx_timeout, 1);
`else
    chk("timeout tied off", rx_timeout, 0);
`endif
    cyc(0,1,0,0,0);
    chk("timeout after pop", rx_timeout, 0);

    // RX clear edge with simultaneous push, overrun cleared.
    do_reset();
    cyc(1,0,0,0,0);
    cyc(1,0,0,0,0);
    chk("char mode overrun", rx_overrun, 1);
    rxclr = 1;
    cyc(1,0,0,0,0);
    chk("rxclr rx_count", rx_count, 0);
    chk("rxclr overrun", rx_overrun, 0);
    pulses = int'(rx_fifo_clr);
    for (int i = 0; i < 4; i++) begin
      cyc(0,0,0,0,0);
      pulses += int'(rx_fifo_clr);
    end
    chk("rxclr pulse count", pulses, 1);

    // Character mode TX then FIFO enable.
    do_reset();
    cyc(0,0,1,0,0);
    cyc(0,0,1,0,0);
    chk("char mode tx_count", tx_count, 1);
    fifoen = 1;
    cyc(0,0,0,0,0);
    chk("fifoen strobes", {rx_fifo_clr, tx_fifo_clr}, 3);
    chk("fifoen counts", {rx_count, tx_count}, 0);

    // TX DMA mode 1.
    do_reset();
    fifoen = 1; dma_mode = 1;
    cyc(0,0,0,0,0);
    cyc(0,0,0,0,0);
    chk("dma tx empty txrdy_n", txrdy_n, 0);
    for (int i = 0; i < 16; i++) cyc(0,0,1,0,0);
    chk("dma tx full count", tx_count, 16);
    chk("dma tx full same cycle", txrdy_n, 0);
    cyc(0,0,0,0,0);
    chk("dma tx full txrdy_n", txrdy_n, 1);
    for (int i = 0; i < 15; i++) cyc(0,0,0,1,0);
    chk("dma tx pop15 txrdy_n", txrdy_n, 1);
    cyc(0,0,0,1,0);
    chk("dma tx empty same cycle", txrdy_n, 1);
    cyc(0,0,0,0,0);
    chk("dma tx empty txrdy_n again", txrdy_n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_fifo_ctrl.md
UART_FIFO_CTRL -- requirements
Module: uart_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, FIFO depth in bytes when FIFOs are enabled.
REQ-002 The block SHALL have parameter TO_CHARS, default 4, character times without RX activity before timeout.
REQ-003 The block SHALL have these ports:
- m_clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- fifoen, rxclr, txclr, dma_mode  in  1 each  FCR level bits.
- rxfiftl  in  4  RX trigger level, in bytes.
- rx_push  in  1  receiver delivers a byte.
- rx_pop  in  1  host reads RBR.
- tx_push  in  1  host writes THR.
- tx_pop  in  1  transmitter takes a byte.
- char_tick  in  1  one-cycle pulse per character time.
- rx_count, tx_count  out  5 each  fill levels.
- rx_fifo_clr, tx_fifo_clr  out  1 each  one-cycle clear strobes to the storage.
- rx_trig  out  1  RX level at or above trigger.
- rx_timeout  out  1  character timeout.
- rx_overrun  out  1  sticky overrun flag.
- rxrdy_n, txrdy_n  out  1 each  DMA ready, active-low.

Function
REQ-004 Capacity SHALL be DEPTH when fifoen=1 and 1 (character mode) when fifoen=0.
REQ-005 A count SHALL update one cycle after push/pop; push+pop in the same cycle leaves it unchanged.
REQ-006 Pop when the count is 0 SHALL be ignored.
REQ-007 Push at capacity SHALL leave the count unchanged; for RX it sets rx_overrun.
REQ-008 A rising edge of rxclr (txclr) SHALL produce one rx_fifo_clr (tx_fifo_clr) pulse and zero the count on the next cycle.
REQ-009 Any change of fifoen SHALL pulse both clears and zero both counts.
REQ-010 A clear SHALL win over a simultaneous push or pop; that push is dropped.
REQ-011 An RX clear SHALL also zero rx_overrun and the timeout counter.
REQ-012 rx_trig SHALL be 1 when fifoen=1, rxfiftl!=0 and rx_count>=rxfiftl; it is combinational from the registered count.
REQ-013 Timeout counter SHALL reset on any rx_push or rx_pop and whenever rx_count=0.
REQ-014 Timeout counter SHALL otherwise increment on char_tick, saturating at TO_CHARS.
REQ-015 rx_timeout SHALL be 1 when the timeout counter equals TO_CHARS and fifoen=1.
REQ-016 With dma_mode=0: rxrdy_n=0 iff rx_count>=1; txrdy_n=0 iff tx_count=0.
REQ-017 With dma_mode=1, RX DMA state: rxrdy_n goes 0 when rx_trig or rx_timeout is 1, and returns to 1 only when rx_count reaches 0.
REQ-018 With dma_mode=1, TX DMA state: txrdy_n goes 0 when tx_count=0, and goes 1 only when tx_count reaches capacity.
REQ-019 The DMA states SHALL be registered, so the outputs change one cycle after the causing count.
REQ-020 A dma_mode change SHALL reload both DMA states from the mode-0 rules on the next cycle.

Reset
REQ-021 Reset SHALL force: counts 0, timeout counter 0, rx_overrun 0, clear strobes 0, rxrdy_n 1, txrdy_n 0.
REQ-022 Reset SHALL load the rxclr/txclr edge registers with 1 and the fifoen history with 0, so the FCR's post-reset values create no strobe.
REQ-023 Reset asserted mid-operation SHALL abandon any pending clear or DMA state immediately.

Configuration
REQ-024 Macro UART_FIFO_CTRL_TIMEOUT_EN defined: the timeout logic per REQ-013 to REQ-015 SHALL be present.
REQ-025 Macro undefined: rx_timeout SHALL be tied 0, no timeout counter is built, and mode-1 rxrdy_n uses rx_trig only.

Structure
REQ-026 Package uart_fifo_pkg SHALL hold the DEPTH default, count width (5), TO_CHARS default and the DMA-state typedef (DMA_IDLE, DMA_ACTIVE).
REQ-027 Sub-module uart_fifo_level SHALL implement one fill counter with push, pop, clear, capacity and overrun; it is instantiated once for RX and once for TX.

Verification
REQ-028 Reset, fifoen=1, 16 rx_push -> rx_count=16; 17th push -> rx_count stays 16, rx_overrun=1.
REQ-029 rxfiftl=8, dma_mode=1, push 8 -> rx_trig=1, rxrdy_n=0 one cycle later; pop 7 -> rxrdy_n stays 0; pop 1 -> rxrdy_n=1.
REQ-030 rx_count=3, 4 char_tick with no push/pop -> rx_timeout=1; a single rx_pop -> rx_timeout=0.
REQ-031 rxclr 0->1 with a simultaneous rx_push -> exactly one rx_fifo_clr pulse, rx_count=0, rx_overrun=0.
REQ-032 fifoen=0, 2 tx_push -> tx_count=1; fifoen 0->1 -> both clear strobes pulse, both counts 0.
REQ-033 dma_mode=1, fill TX to 16 -> txrdy_n=1; pop to 1 -> still 1; pop to 0 -> txrdy_n=0.
